// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the per-word ones-count pipeline.
package popcount_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DROP = 1'b1
  } acc_state_t;

  // Bits needed to hold a per-word count in the range 0..width.
  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

  // Bits needed to hold a word count in the range 1..max_words.
  function automatic int words_width(input int max_words);
    return $clog2(max_words) + 1;
  endfunction

  // Bits needed to hold a frame total up to width*max_words without wrapping.
  function automatic int total_width(input int width, input int max_words);
    return $clog2(width * max_words) + 1;
  endfunction

endpackage

// File: rtl/acc_out_stage.sv
// Frame result registers with a valid/ready handshake; a new result may load
// on the same edge the current one is consumed.
module acc_out_stage #(
  parameter int CW = 4,
  parameter int WW = 9,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] res_total,
  input  logic [WW-1:0] res_words,
  input  logic [CW-1:0] res_max,
  input  logic          res_over,
  input  logic          res_trunc,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [AW-1:0] out_total,
  output logic [WW-1:0] out_words,
  output logic [CW-1:0] out_max,
  output logic          out_over,
  output logic          out_trunc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_total <= '0;
      out_words <= '0;
      out_max   <= '0;
      out_over  <= 1'b0;
      out_trunc <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_total <= res_total;
      out_words <= res_words;
      out_max   <= res_max;
      out_over  <= res_over;
      out_trunc <= res_trunc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ones_frame_accumulator.sv
// Accumulates per-word ones counts into per-frame statistics, truncating
// frames longer than MAX_WORDS and dropping their remaining beats.
module ones_frame_accumulator
  import popcount_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_WORDS = 256,
  localparam int CW        = count_width(WIDTH),
  localparam int WW        = words_width(MAX_WORDS),
  localparam int AW        = total_width(WIDTH, MAX_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_count,
  input  logic          in_last,
  input  logic [AW-1:0] threshold,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_total,
  output logic [WW-1:0] out_words,
  output logic [CW-1:0] out_max,
  output logic          out_over,
  output logic          out_trunc,
  output logic          err_range
);

  acc_state_t    state, state_next;
  logic [AW-1:0] acc_total, sum_total;
  logic [WW-1:0] acc_words, sum_words;
  logic [CW-1:0] acc_max, sum_max, cnt;
  logic          over_range, accept, at_limit, close;

  assign over_range = in_count > CW'(WIDTH);
  assign cnt        = over_range ? CW'(WIDTH) : in_count;
  assign accept     = in_valid && in_ready;

  // Values the accumulators would take if this beat is accumulated.
  assign sum_total = acc_total + AW'(cnt);
  assign sum_words = acc_words + WW'(1);
  assign sum_max   = (cnt > acc_max) ? cnt : acc_max;
  assign at_limit  = sum_words == WW'(MAX_WORDS);

  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      ACC:     if (close && !in_last) state_next = DROP;
      DROP:    if (accept && in_last) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  always_comb begin
    in_ready = 1'b1;
    close    = 1'b0;
    case (state)
      ACC: begin
        in_ready = !out_valid || out_ready;
        close    = in_valid && in_ready && (in_last || at_limit);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_total <= '0;
      acc_words <= '0;
      acc_max   <= '0;
    end else if (state == ACC && accept) begin
      if (close) begin
        acc_total <= '0;
        acc_words <= '0;
        acc_max   <= '0;
      end else begin
        acc_total <= sum_total;
        acc_words <= sum_words;
        acc_max   <= sum_max;
      end
    end
  end

  // Sticky across frames, including beats discarded in DROP.
  always_ff @(posedge clk) begin
    if (rst)                       err_range <= 1'b0;
    else if (accept && over_range) err_range <= 1'b1;
  end

  acc_out_stage #(
    .CW(CW),
    .WW(WW),
    .AW(AW)
  ) u_out_stage (
    .clk      (clk),
    .rst      (rst),
    .load     (close),
    .res_total(sum_total),
    .res_words(sum_words),
    .res_max  (sum_max),
    .res_over (sum_total >= threshold),
    .res_trunc(!in_last),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_total(out_total),
    .out_words(out_words),
    .out_max  (out_max),
    .out_over (out_over),
    .out_trunc(out_trunc)
  );

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// Directed bench for ones_frame_accumulator with WIDTH=8, MAX_WORDS=4.
module tb_ones_frame_accumulator;

  localparam int WIDTH     = 8;
  localparam int MAX_WORDS = 4;
  localparam int CW        = 4;
  localparam int WW        = 3;
  localparam int AW        = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_count;
  logic          in_last;
  logic [AW-1:0] threshold;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_total;
  logic [WW-1:0] out_words;
  logic [CW-1:0] out_max;
  logic          out_over;
  logic          out_trunc;
  logic          err_range;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ones_frame_accumulator #(
    .WIDTH    (WIDTH),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_count (in_count),
    .in_last  (in_last),
    .threshold(threshold),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_total(out_total),
    .out_words(out_words),
    .out_max  (out_max),
    .out_over (out_over),
    .out_trunc(out_trunc),
    .err_range(err_range)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are read there too.
  task automatic drive(input logic v, input int c, input logic l);
    in_valid = v;
    in_count = CW'(c);
    in_last  = l;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input int total, input int words,
                              input int mx, input logic over, input logic trunc);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".total"}, 32'(out_total), 32'(total));
    check({tag, ".words"}, 32'(out_words), 32'(words));
    check({tag, ".max"},   32'(out_max),   32'(mx));
    check({tag, ".over"},  32'(out_over),  32'(over));
    check({tag, ".trunc"}, 32'(out_trunc), 32'(trunc));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_count  = '0;
    in_last   = 1'b0;
    threshold = AW'(16);
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst.valid",    32'(out_valid), 32'd0);
    check("rst.total",    32'(out_total), 32'd0);
    check("rst.err",      32'(err_range), 32'd0);
    check("rst.in_ready", 32'(in_ready),  32'd1);

    // 1: 3,8,0,5 with threshold 16 -> total hits threshold exactly
    drive(1, 3, 0); tick();
    check("t1.valid_early", 32'(out_valid), 32'd0);
    drive(1, 8, 0); tick();
    drive(1, 0, 0); tick();
    check("t1.valid_3rd", 32'(out_valid), 32'd0);
    drive(1, 5, 1); tick();
    check_result("t1", 16, 4, 8, 1'b1, 1'b0);
    drive(0, 0, 0); tick();
    check("t1.valid_clear", 32'(out_valid), 32'd0);

    // 2: 1,1,1,1,2,2(last) -> truncated after 4, beats 5-6 dropped
    drive(1, 1, 0); tick();
    drive(1, 1, 0); tick();
    drive(1, 1, 0); tick();
    drive(1, 1, 0); tick();
    check_result("t2", 4, 4, 1, 1'b0, 1'b1);
    drive(1, 2, 0);
    check("t2.drop_ready", 32'(in_ready), 32'd1);
    tick();
    check("t2.drop5_valid", 32'(out_valid), 32'd0);
    drive(1, 2, 1); tick();
    check("t2.drop6_valid", 32'(out_valid), 32'd0);
    drive(1, 7, 1); tick();
    check_result("t2.next", 7, 1, 7, 1'b0, 1'b0);
    drive(0, 0, 0); tick();
    check("t2.valid_clear", 32'(out_valid), 32'd0);

    // 3: six back-to-back 1-word frames
    for (int i = 0; i < 6; i++) begin
      drive(1, i, 1);
      check($sformatf("t3.ready%0d", i), 32'(in_ready), 32'd1);
      tick();
      check($sformatf("t3.valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("t3.total%0d", i), 32'(out_total), 32'(i));
    end
    drive(0, 0, 0); tick();
    check("t3.valid_clear", 32'(out_valid), 32'd0);

    // 4: backpressure holds result and stalls input
    drive(1, 2, 1); tick();
    check_result("t4", 2, 1, 2, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive(1, 4, 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4.stall_ready%0d", i), 32'(in_ready), 32'd0);
      tick();
      check($sformatf("t4.hold_total%0d", i), 32'(out_total), 32'd2);
      check($sformatf("t4.hold_valid%0d", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("t4.release_ready", 32'(in_ready), 32'd1);
    tick();
    check_result("t4.next", 4, 1, 4, 1'b0, 1'b0);
    drive(0, 0, 0); tick();
    check("t4.valid_clear", 32'(out_valid), 32'd0);

    // 5: over-range count clamps and latches err_range
    check("t5.err_before", 32'(err_range), 32'd0);
    drive(1, 12, 0); tick();
    check("t5.err_set", 32'(err_range), 32'd1);
    drive(1, 1, 1); tick();
    check_result("t5", 9, 2, 8, 1'b0, 1'b0);
    drive(1, 1, 1); tick();
    check_result("t5.later", 1, 1, 1, 1'b0, 1'b0);
    check("t5.err_sticky", 32'(err_range), 32'd1);
    drive(0, 0, 0); tick();

    // 6a: reset with a pending result
    out_ready = 1'b0;
    drive(1, 5, 1); tick();
    check("t6.pending", 32'(out_valid), 32'd1);
    drive(0, 0, 0);
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    check("t6.rst_valid", 32'(out_valid), 32'd0);
    check("t6.rst_total", 32'(out_total), 32'd0);
    check("t6.rst_words", 32'(out_words), 32'd0);
    check("t6.rst_max",   32'(out_max),   32'd0);
    check("t6.rst_err",   32'(err_range), 32'd0);
    check("t6.rst_ready", 32'(in_ready),  32'd1);

    // 6b: reset mid-frame after two beats discards the partial frame
    out_ready = 1'b1;
    drive(1, 6, 0); tick();
    drive(1, 6, 0); tick();
    drive(0, 0, 0);
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    check("t6.mid_valid", 32'(out_valid), 32'd0);
    drive(1, 3, 1); tick();
    check_result("t6.next", 3, 1, 3, 1'b0, 1'b0);
    drive(0, 0, 0); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
